pipemem_access: RTL

// - MEM-stage consumer of the EX/MEM register outputs (mwreg, mm2reg, mwmem, malu, mb, mrn).
// - Runs a req/ack handshake to a multi-cycle data memory and stalls the pipeline until the access completes.
// - Drives the MEM/WB register (wwreg, wm2reg, wmo, walu, wrn) that feeds writeback.

---
 rtl/pipemem_access_if.sv | 27 ++
 rtl/pipemem_access.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipemem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and a multi-cycle memory (slave).
interface pipemem_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/pipemem_access.sv
// MEM stage: runs a req/ack access to a multi-cycle data memory, stalls until it completes,
// and fills the MEM/WB register. Optional macro MISALIGN_TRAP_EN traps misaligned accesses.
module pipemem_access #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  input  logic [4:0]       mrn,
  pipemem_access_if.master dmem,
  output logic             mem_stall,
  output logic             mem_err,
  output logic             wwreg,
  output logic             wm2reg,
  output logic [31:0]      wmo,
  output logic [31:0]      walu,
  output logic [4:0]       wrn
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CntMax  = TO_W'(TIMEOUT);

  state_e          state;
  logic [TO_W-1:0] cnt;
  logic            memop;
  logic            is_load;
  logic            expired;
  logic            misalign;

  // A store wins when mm2reg and mwmem are both set.
  assign memop   = mm2reg | mwmem;
  assign is_load = mm2reg & ~mwmem;
  assign expired = (TIMEOUT != 0) && (state == StReq) && !dmem.ack && (cnt == CntLast);

`ifdef MISALIGN_TRAP_EN
  assign misalign = (malu[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_stall = ((state == StIdle) && memop && !misalign) ||
                     ((state == StReq) && !dmem.ack && !expired);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= '0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.wdata <= '0;
      mem_err    <= 1'b0;
      wwreg      <= 1'b0;
      wm2reg     <= 1'b0;
      wmo        <= '0;
      walu       <= '0;
      wrn        <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        StIdle: begin
          if (!memop) begin
            wwreg  <= mwreg;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= malu;
            wrn    <= mrn;
          end else if (misalign) begin
            wwreg   <= 1'b0;
            wm2reg  <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            state      <= StReq;
            cnt        <= '0;
            dmem.req   <= 1'b1;
            dmem.we    <= mwmem;
            dmem.addr  <= {malu[31:2], 2'b00};
            dmem.wdata <= mb;
            wwreg      <= 1'b0;
            wm2reg     <= 1'b0;
          end
        end
        StReq: begin
          // EX/MEM is frozen while stalled, so its fields still describe this access.
          if (dmem.ack) begin
            state    <= StIdle;
            dmem.req <= 1'b0;
            wwreg    <= mwreg;
            wm2reg   <= is_load;
            wmo      <= is_load ? dmem.rdata : 32'h0;
            walu     <= malu;
            wrn      <= mrn;
          end else if (expired) begin
            state    <= StIdle;
            dmem.req <= 1'b0;
            mem_err  <= 1'b1;
            wwreg    <= 1'b0;
            wm2reg   <= 1'b0;
          end else begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            if (cnt != CntMax) begin
              cnt <= cnt + TO_W'(1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
